// File: rtl/mxu_result_deskew.sv
// mxu_result_deskew: re-aligns the diagonally skewed MXU result vector into
// row words, buffers them in a show-ahead FIFO and frames each tile with last/done.
module mxu_result_deskew #(
    parameter int M     = 3,
    parameter int DW    = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CW-1:0]   num_rows,
    input  logic            in_valid,
    input  logic [M*DW-1:0] y,
    output logic [M*DW-1:0] m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_last,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    localparam int W  = M * DW;
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] L_PTR_ONE = AW'(1);
    localparam logic [AW:0]   L_CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   L_FULL    = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] L_ROW_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN
    } state_t;

    // Stage s holds lanes 0..s; lane j joins the chain at stage j.
    logic [W-1:0]   r_sk [M-1];
    logic [M-2:0]   r_vp;

    logic [W:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wp;
    logic [AW-1:0]  r_rp;
    logic [AW:0]    r_cnt;

    state_t         r_state;
    logic [CW-1:0]  r_nrows;
    logic [CW-1:0]  r_rows;
    logic           r_done;
    logic           r_ovf;

    logic [W-1:0]   w_lane_top;
    logic [W-1:0]   w_word;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_wr;
    logic           w_drop;
    logic [CW-1:0]  w_rows_nx;
    logic           w_last;
    logic [AW:0]    w_cnt_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < M - 1; s++) begin
                r_sk[s] <= '0;
            end
            r_vp <= '0;
        end else begin
            r_sk[0] <= W'(y[DW-1:0]);
            for (int s = 1; s < M - 1; s++) begin
                r_sk[s]               <= r_sk[s-1];
                r_sk[s][s*DW +: DW]   <= y[s*DW +: DW];
            end
            r_vp[0] <= in_valid;
            for (int s = 1; s < M - 1; s++) begin
                r_vp[s] <= r_vp[s-1];
            end
        end
    end

    // The top lane of the last stage is always zero, so OR-in the live lane.
    always_comb begin
        w_lane_top                  = '0;
        w_lane_top[(M-1)*DW +: DW]  = y[(M-1)*DW +: DW];
        w_word                      = r_sk[M-2] | w_lane_top;
    end

    assign w_push    = r_vp[M-2] & (r_state == S_COLLECT);
    assign m_valid   = (r_cnt != '0);
    assign w_pop     = m_valid & m_ready;
    assign w_full    = (r_cnt == L_FULL);
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_rows_nx = r_rows + L_ROW_ONE;
    assign w_last    = (w_rows_nx == r_nrows);

    always_comb begin
        w_cnt_nx = r_cnt;
        unique case ({w_wr, w_pop})
            2'b10:   w_cnt_nx = r_cnt + L_CNT_ONE;
            2'b01:   w_cnt_nx = r_cnt - L_CNT_ONE;
            default: w_cnt_nx = r_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= {w_last, w_word};
                r_wp        <= r_wp + L_PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + L_PTR_ONE;
            end
            r_cnt <= w_cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_nrows <= L_ROW_ONE;
            r_rows  <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // An overflow event wins over a clearing start in the same cycle.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (start && (r_state == S_IDLE)) begin
                r_ovf <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_nrows <= (num_rows == '0) ? L_ROW_ONE : num_rows;
                        r_rows  <= '0;
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_push) begin
                        r_rows <= w_rows_nx;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_cnt_nx == '0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_data   = m_valid ? r_mem[r_rp][W-1:0] : '0;
    assign m_last   = m_valid & r_mem[r_rp][W];
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_mxu_result_deskew.sv
// tb_mxu_result_deskew: scoreboard bench for the MXU result de-skew FIFO,
// covering alignment, framing, overflow, simultaneous pop and reset.
module tb_mxu_result_deskew;

    localparam int M     = 3;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int W     = M * DW;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [CW-1:0]   num_rows;
    logic            in_valid;
    logic [W-1:0]    y;
    logic [W-1:0]    m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;
    logic            busy;
    logic            done;
    logic            overflow;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [W:0]      sb [$];
    logic [W-1:0]    rows [$];

    always #5 clk = ~clk;

    mxu_result_deskew #(
        .M     (M),
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_rows (num_rows),
        .in_valid (in_valid),
        .y        (y),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Every accepted handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("unexp_word", 32'(m_valid), 32'(0));
            end else begin
                logic [W:0] e;
                e = sb.pop_front();
                check("m_data", 32'(m_data), 32'(e[W-1:0]));
                check("m_last", 32'(m_last), 32'(e[W]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        num_rows = CW'(n);
        tick();
        start    = 1'b0;
    endtask

    task automatic send(input int keep, input int nrows, input int rdy_c);
        int         n;
        int         nr;
        logic [W-1:0] r;
        n  = rows.size();
        nr = (nrows == 0) ? 1 : nrows;
        for (int i = 0; i < keep; i++) begin
            sb.push_back({1'(i == nr - 1), rows[i]});
        end
        for (int c = 0; c < n + M - 1; c++) begin
            if (c == rdy_c) m_ready = 1'b1;
            in_valid = (c < n);
            for (int j = 0; j < M; j++) begin
                if (c - j >= 0 && c - j < n) begin
                    r = rows[c-j];
                    y[j*DW +: DW] = r[j*DW +: DW];
                end else begin
                    y[j*DW +: DW] = DW'($urandom);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        y        = W'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done"}, 32'(seen), 32'(1));
        tick();
        check({tag, "_pulse"}, 32'(done), 32'(0));
        check({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        num_rows = '0;
        in_valid = 1'b1;
        m_ready  = 1'b0;
        y        = W'($urandom);
        repeat (2) tick();
        check("rst_valid", 32'(m_valid), 32'(0));
        check("rst_data", 32'(m_data), 32'(0));
        check("rst_last", 32'(m_last), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (4) tick();
        check("rel_valid", 32'(m_valid), 32'(0));

        // Single row
        m_ready = 1'b1;
        do_start(1);
        check("sr_busy", 32'(busy), 32'(1));
        rows = '{12'h253};
        send(1, 1, -1);
        check("sr_valid", 32'(m_valid), 32'(1));
        check("sr_data", 32'(m_data), 32'(12'h253));
        check("sr_last", 32'(m_last), 32'(1));
        wait_done("sr", 10);

        // Back-to-back stream
        do_start(4);
        rows = '{12'h253, 12'h353, 12'h463, 12'h564};
        send(4, 4, -1);
        check("b2b_rate", 32'(sb.size()), 32'(1));
        check("b2b_last", 32'(m_last), 32'(1));
        check("b2b_ovf", 32'(overflow), 32'(0));
        wait_done("b2b", 10);

        // Overflow with the final word dropped
        m_ready = 1'b0;
        do_start(6);
        rows = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666};
        send(4, 6, -1);
        check("ovf_set", 32'(overflow), 32'(1));
        check("ovf_busy", 32'(busy), 32'(1));
        check("ovf_head", 32'(m_data), 32'(12'h111));
        m_ready = 1'b1;
        wait_done("ovf", 20);
        check("ovf_sticky", 32'(overflow), 32'(1));

        // Full FIFO with a pop on the same cycle as a push
        m_ready = 1'b0;
        do_start(5);
        check("ovf_clr", 32'(overflow), 32'(0));
        rows = '{12'h7a1, 12'h8b2, 12'h9c3, 12'had4, 12'hbe5};
        send(5, 5, 6);
        check("fp_ovf", 32'(overflow), 32'(0));
        wait_done("fp", 20);

        // Rows in IDLE are ignored
        rows = '{12'h0f0, 12'h1e1};
        send(0, 2, -1);
        repeat (3) tick();
        check("idle_valid", 32'(m_valid), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));

        // Reset in the middle of a tile
        m_ready = 1'b0;
        do_start(5);
        rows = '{12'h321, 12'h654};
        send(0, 5, -1);
        check("mt_fill", 32'(m_valid), 32'(1));
        reset = 1'b0;
        #1;
        check("mt_valid", 32'(m_valid), 32'(0));
        check("mt_busy", 32'(busy), 32'(0));
        repeat (2) tick();
        reset = 1'b1;
        tick();

        m_ready = 1'b1;
        do_start(1);
        rows = '{12'h253};
        send(1, 1, -1);
        check("pr_data", 32'(m_data), 32'(12'h253));
        check("pr_last", 32'(m_last), 32'(1));
        wait_done("pr", 10);

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
